// File: rtl/eth_mdio_controller.sv
// Clause-22 MDIO management master: one command in, one 64-slot frame out,
// one response pulse back. MDC and MDIO drive are fully registered.
module eth_mdio_controller #(
    parameter int CLK_DIV      = 20,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    localparam int N  = PREAMBLE_LEN + 32;
    localparam int PW = 9;
    localparam int BW = 7;
    localparam int SH = 32 - PREAMBLE_LEN;

    localparam logic [PW-1:0] PH_HI    = PW'(CLK_DIV);
    localparam logic [PW-1:0] PH_LAST  = PW'(2 * CLK_DIV - 1);
    localparam logic [BW-1:0] REG_LSB  = BW'(PREAMBLE_LEN + 13);
    localparam logic [BW-1:0] TA_IDX   = BW'(PREAMBLE_LEN + 14);
    localparam logic [BW-1:0] TA2_IDX  = BW'(PREAMBLE_LEN + 15);
    localparam logic [BW-1:0] LAST_IDX = BW'(N - 1);
    localparam logic [63:0]   PRE_MASK = ~({64{1'b1}} >> PREAMBLE_LEN);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        TURN,
        DATA,
        DONE
    } state_e;

    state_e        state_q;
    logic [PW-1:0] phase_q, phase_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [63:0]   tx_q, tx_d;
    logic [31:0]   frame_d;
    logic [15:0]   rx_q;
    logic          wr_q;
    logic          ta_err_q;
    logic          cmd_ready_q;
    logic          busy_q;
    logic          mdc_q, mdc_d;
    logic          mdio_o_q;
    logic          mdio_oe_q;
    logic          rsp_valid_q;
    logic [15:0]   rsp_rdata_q;
    logic          rsp_error_q;
    logic          slot_end;
    logic          sample;

    always_comb begin
        phase_d  = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        bit_d    = bit_q + 1'b1;
        mdc_d    = (phase_d >= PH_HI);
        slot_end = (phase_q == PH_LAST);
        sample   = (phase_q == PH_HI);
        frame_d  = {2'b01,
                    cmd_write ? 2'b01 : 2'b10,
                    cmd_phy_addr,
                    cmd_reg_addr,
                    cmd_write ? 2'b10 : 2'b11,
                    cmd_write ? cmd_wdata : 16'h0000};
        // Preamble ones sit above the 32 frame bits; MSB is sent first.
        tx_d     = (64'(frame_d) << SH) | PRE_MASK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            wr_q        <= 1'b0;
            ta_err_q    <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            mdc_q       <= 1'b0;
            mdio_o_q    <= 1'b1;
            mdio_oe_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        state_q     <= SHIFT;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        phase_q     <= '0;
                        bit_q       <= '0;
                        wr_q        <= cmd_write;
                        ta_err_q    <= 1'b0;
                        mdc_q       <= 1'b0;
                        mdio_oe_q   <= 1'b1;
                        mdio_o_q    <= tx_d[63];
                        tx_q        <= tx_d << 1;
                    end
                end
                SHIFT, TURN, DATA: begin
                    phase_q <= phase_d;
                    mdc_q   <= mdc_d;
                    if (sample && state_q == TURN && bit_q == TA2_IDX) begin
                        ta_err_q <= mdio_i;
                    end
                    if (sample && state_q == DATA) begin
                        rx_q <= {rx_q[14:0], mdio_i};
                    end
                    if (slot_end) begin
                        if (bit_q == LAST_IDX) begin
                            state_q     <= DONE;
                            mdc_q       <= 1'b0;
                            mdio_oe_q   <= 1'b0;
                            mdio_o_q    <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= wr_q ? 16'h0000 : rx_q;
                            rsp_error_q <= wr_q ? 1'b0 : ta_err_q;
                        end else begin
                            bit_q     <= bit_d;
                            mdio_o_q  <= tx_q[63];
                            tx_q      <= tx_q << 1;
                            mdio_oe_q <= wr_q || (bit_d < TA_IDX);
                            if (bit_q == REG_LSB) begin
                                state_q <= TURN;
                            end
                            if (bit_q == TA2_IDX) begin
                                state_q <= DATA;
                            end
                        end
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign mdc       = mdc_q;
    assign mdio_o    = mdio_o_q;
    assign mdio_oe   = mdio_oe_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_eth_mdio_controller.sv
// Bench for eth_mdio_controller: two parameterizations behind one mux,
// slot-level frame model and a simple PHY that answers reads.
module tb_eth_mdio_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        cmd_valid;
    logic        cmd_write;
    logic [4:0]  cmd_phy_addr;
    logic [4:0]  cmd_reg_addr;
    logic [15:0] cmd_wdata;
    logic        mdio_i;

    logic        a_ready, a_rv, a_err, a_busy, a_mdc, a_mo, a_oe;
    logic [15:0] a_rd;
    logic        b_ready, b_rv, b_err, b_busy, b_mdc, b_mo, b_oe;
    logic [15:0] b_rd;

    logic        cmd_ready, rsp_valid, rsp_error, busy, mdc, mdio_o, mdio_oe;
    logic [15:0] rsp_rdata;

    int n_chk;
    int n_pass;

    always #5 clk = ~clk;

    eth_mdio_controller #(.CLK_DIV(2), .PREAMBLE_LEN(32)) u_dut_a (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid & ~sel), .cmd_ready(a_ready),
        .cmd_write(cmd_write), .cmd_phy_addr(cmd_phy_addr),
        .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(a_rv), .rsp_rdata(a_rd), .rsp_error(a_err),
        .busy(a_busy), .mdc(a_mdc), .mdio_o(a_mo), .mdio_oe(a_oe),
        .mdio_i(mdio_i)
    );

    eth_mdio_controller #(.CLK_DIV(3), .PREAMBLE_LEN(0)) u_dut_b (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid & sel), .cmd_ready(b_ready),
        .cmd_write(cmd_write), .cmd_phy_addr(cmd_phy_addr),
        .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(b_rv), .rsp_rdata(b_rd), .rsp_error(b_err),
        .busy(b_busy), .mdc(b_mdc), .mdio_o(b_mo), .mdio_oe(b_oe),
        .mdio_i(mdio_i)
    );

    assign cmd_ready = sel ? b_ready : a_ready;
    assign rsp_valid = sel ? b_rv    : a_rv;
    assign rsp_rdata = sel ? b_rd    : a_rd;
    assign rsp_error = sel ? b_err   : a_err;
    assign busy      = sel ? b_busy  : a_busy;
    assign mdc       = sel ? b_mdc   : a_mdc;
    assign mdio_o    = sel ? b_mo    : a_mo;
    assign mdio_oe   = sel ? b_oe    : a_oe;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Bit on the wire in slot s, derived from the frame layout.
    function automatic logic tx_bit(int s, int p, logic wr,
                                    logic [4:0] pa, logic [4:0] ra,
                                    logic [15:0] wd);
        logic [31:0] f;
        f = {2'b01, wr ? 2'b01 : 2'b10, pa, ra, 2'b10, wd};
        if (s < p) return 1'b1;
        return f[31 - (s - p)];
    endfunction

    // What the PHY (or the pull-up) puts on the line in slot s.
    function automatic logic phy_bit(int s, int p, logic ta2,
                                     logic [15:0] rd);
        if (s == p + 15) return ta2;
        if (s >= p + 16 && s < p + 32) return rd[15 - (s - p - 16)];
        return 1'b1;
    endfunction

    task automatic issue(input logic wr, input logic [4:0] pa,
                         input logic [4:0] ra, input logic [15:0] wd);
        int k;
        k = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 1000) check("ready_timeout", 64'(cmd_ready), 64'(1));
        cmd_write    = wr;
        cmd_phy_addr = pa;
        cmd_reg_addr = ra;
        cmd_wdata    = wd;
        cmd_valid    = 1'b1;
        @(posedge clk);
    endtask

    // Starts right after the accept edge; checks the frame and response.
    task automatic run_frame(input logic wr, input logic [4:0] pa,
                             input logic [4:0] ra, input logic [15:0] wd,
                             input logic ta2, input logic [15:0] rd,
                             input logic hold, output logic [63:0] strm);
        int cd, p, n, len, s, ph;
        int e_mdc, e_oe, e_mo, e_busy, vpos, vcnt, oe_drop;
        logic pm;
        logic [15:0] got_rd, exp_rd;
        logic got_err, exp_err;
        cd = sel ? 3 : 2;
        p  = sel ? 0 : 32;
        n  = p + 32;
        len = n * 2 * cd;
        e_mdc = 0; e_oe = 0; e_mo = 0; e_busy = 0;
        vpos = -1; vcnt = 0; oe_drop = n;
        pm = 1'b0;
        strm = '0;
        got_rd = '0; got_err = 1'b0;
        exp_rd  = wr ? 16'h0000 : rd;
        exp_err = wr ? 1'b0 : ta2;
        for (int c = 1; c <= len + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("busy_on", 64'(busy), 64'(1));
                check("ready_off", 64'(cmd_ready), 64'(0));
                if (!hold) cmd_valid = 1'b0;
                cmd_write    = 1'($urandom);
                cmd_phy_addr = 5'($urandom);
                cmd_reg_addr = 5'($urandom);
                cmd_wdata    = 16'($urandom);
            end
            if (rsp_valid === 1'b1) begin
                vcnt++;
                if (vpos < 0) vpos = c;
            end
            if (c == len + 1) begin
                got_rd  = rsp_rdata;
                got_err = rsp_error;
            end
            if (c <= len) begin
                s  = (c - 1) / (2 * cd);
                ph = (c - 1) % (2 * cd);
                if (mdc !== (ph >= cd)) e_mdc++;
                if (mdio_oe !== (wr || s < p + 14)) e_oe++;
                if (mdio_oe === 1'b0 && oe_drop == n) oe_drop = s;
                if (mdio_oe === 1'b1 && mdio_o !== tx_bit(s, p, wr, pa, ra, wd))
                    e_mo++;
                if (busy !== 1'b1 || cmd_ready !== 1'b0) e_busy++;
                if (mdc === 1'b1 && !pm)
                    strm = {strm[62:0], mdio_oe ? mdio_o : mdio_i};
                pm = mdc;
                mdio_i = wr ? 1'b1 : phy_bit(s, p, ta2, rd);
            end
        end
        mdio_i = 1'b1;
        check("mdc_wave", 64'(e_mdc), 64'(0));
        check("oe_wave", 64'(e_oe), 64'(0));
        check("mdo_bits", 64'(e_mo), 64'(0));
        check("busy_frame", 64'(e_busy), 64'(0));
        check("oe_drop_slot", 64'(oe_drop), 64'(wr ? n : p + 14));
        check("rsp_cycle", 64'(vpos), 64'(len + 1));
        check("rsp_count", 64'(vcnt), 64'(1));
        check("rsp_rdata", 64'(got_rd), 64'(exp_rd));
        check("rsp_error", 64'(got_err), 64'(exp_err));
        @(negedge clk);
        check("ready_back", 64'(cmd_ready), 64'(1));
        check("busy_off", 64'(busy), 64'(0));
        check("rv_pulse", 64'(rsp_valid), 64'(0));
        check("rdata_hold", 64'(rsp_rdata), 64'(exp_rd));
        check("idle_pins", 64'({mdc, mdio_oe, mdio_o}), 64'(3'b001));
    endtask

    initial begin
        logic [63:0] strm;
        logic        bw, ta2;
        logic [4:0]  bpa, bra;
        logic [15:0] bwd, rd;
        int          nrv;
        n_chk = 0;
        n_pass = 0;
        reset = 1'b1;
        sel = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_phy_addr = '0;
        cmd_reg_addr = '0;
        cmd_wdata = '0;
        mdio_i = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sel = d[0];
            #1;
            check("rst_ready", 64'(cmd_ready), 64'(0));
            check("rst_pins", 64'({busy, mdc, mdio_oe, mdio_o}), 64'(4'b0001));
            check("rst_rsp", 64'({rsp_valid, rsp_error, rsp_rdata}), 64'(0));
        end
        sel = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'({a_ready, b_ready}), 64'(2'b11));

        issue(1'b1, 5'd1, 5'd0, 16'h8000);
        run_frame(1'b1, 5'd1, 5'd0, 16'h8000, 1'b0, 16'h0, 1'b0, strm);
        check("wr_stream", strm, 64'hFFFF_FFFF_5082_8000);

        issue(1'b0, 5'd1, 5'd2, 16'h1234);
        run_frame(1'b0, 5'd1, 5'd2, 16'h1234, 1'b0, 16'h2000, 1'b0, strm);

        issue(1'b0, 5'd1, 5'd2, 16'h0);
        run_frame(1'b0, 5'd1, 5'd2, 16'h0, 1'b1, 16'hFFFF, 1'b0, strm);

        // Back-to-back with cmd_valid held; fields change during frame A.
        issue(1'b0, 5'd7, 5'd9, 16'h0);
        run_frame(1'b0, 5'd7, 5'd9, 16'h0, 1'b0, 16'hA55A, 1'b1, strm);
        bw = cmd_write; bpa = cmd_phy_addr; bra = cmd_reg_addr;
        bwd = cmd_wdata;
        rd = 16'($urandom);
        run_frame(bw, bpa, bra, bwd, 1'b0, rd, 1'b0, strm);

        for (int d = 0; d < 2; d++) begin
            sel = d[0];
            for (int i = 0; i < 5; i++) begin
                bw  = 1'($urandom);
                bpa = 5'($urandom);
                bra = 5'($urandom);
                bwd = 16'($urandom);
                ta2 = ($urandom_range(0, 3) == 0);
                rd  = 16'($urandom);
                issue(bw, bpa, bra, bwd);
                run_frame(bw, bpa, bra, bwd, ta2, rd, 1'b0, strm);
            end
        end

        // Reset at the start of slot 20 of a read.
        sel = 1'b0;
        issue(1'b0, 5'd3, 5'd4, 16'h0);
        cmd_valid = 1'b0;
        repeat (81) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_pins", 64'({mdc, mdio_oe, busy, rsp_valid}), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready", 64'(cmd_ready), 64'(1));
        nrv = 0;
        repeat (300) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) nrv++;
        end
        check("abort_no_rsp", 64'(nrv), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
